// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Desc     : Opcode/state encodings and opcode-class helpers for alu_mc.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_SLT   = 5'd2,  ALU_SLTU  = 5'd3,
        ALU_XOR    = 5'd4,  ALU_OR     = 5'd5,  ALU_AND   = 5'd6,  ALU_SLL   = 5'd7,
        ALU_SRL    = 5'd8,  ALU_SRA    = 5'd9,  ALU_MUL   = 5'd10, ALU_MULH  = 5'd11,
        ALU_MULHSU = 5'd12, ALU_MULHU  = 5'd13, ALU_DIV   = 5'd14, ALU_DIVU  = 5'd15,
        ALU_REM    = 5'd16, ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Operand A interpreted as signed.
    function automatic logic is_signed_op(input logic [4:0] op);
        return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return op inside {ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_div_iter
// Desc     : Unsigned restoring radix-2 divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;

    // The quotient register doubles as the dividend shifter.
    assign w_trial = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_div};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (!w_diff[WIDTH]) begin
                r_rem  <= w_diff[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_trial[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done      = r_busy & (r_cnt == c_LAST);
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Desc     : Multi-cycle RV32IM-style ALU with valid/ready on both sides.
//            Define ALU_MC_FAST_MUL_EN for a single-cycle registered multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [4:0]       i_alu_op,
    input  logic             i_kill,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_alu_data,
    output logic             o_busy
);

    localparam int c_SHW = $clog2(WIDTH);

    alu_state_e        r_state;
    alu_state_e        w_state_nxt;
    logic              w_accept;
    logic              w_go_iter;
    logic              w_iter_done;
    logic              w_sa;
    logic              w_sb;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [c_SHW-1:0]  w_shamt;
    logic [WIDTH-1:0]  w_basic_res;
    logic [WIDTH-1:0]  w_fix_res;
    logic              w_div_done;
    logic [WIDTH-1:0]  w_quot;
    logic [WIDTH-1:0]  w_rem;

    logic [4:0]        r_op;
    logic [WIDTH-1:0]  r_op_a;
    logic              r_b_zero;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [WIDTH-1:0]  r_result;

    assign w_accept = i_valid & o_ready & ~i_kill;
    assign w_sa     = is_signed_op(i_alu_op) & i_op_a[WIDTH-1];
    assign w_sb     = is_signed_b(i_alu_op) & i_op_b[WIDTH-1];
    assign w_mag_a  = w_sa ? -i_op_a : i_op_a;
    assign w_mag_b  = w_sb ? -i_op_b : i_op_b;
    assign w_shamt  = i_op_b[c_SHW-1:0];

`ifdef ALU_MC_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fa;
    logic [2*WIDTH-1:0] w_fb;
    logic [2*WIDTH-1:0] w_fprod;

    // Sign-extended to 2*WIDTH: the low 2*WIDTH product bits match a (WIDTH+1)-bit signed multiply.
    assign w_fa        = {{WIDTH{w_sa}}, i_op_a};
    assign w_fb        = {{WIDTH{w_sb}}, i_op_b};
    assign w_fprod     = w_fa * w_fb;
    assign w_go_iter   = is_div(i_alu_op);
    assign w_iter_done = w_div_done;
`else
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);

    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [c_SHW-1:0]   r_cnt;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_prod;

    // Shift-add on magnitudes; multiplier enters in the low half and is shifted out.
    assign w_msum      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_prod      = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_go_iter   = is_div(i_alu_op) | is_mul(i_alu_op);
    assign w_iter_done = is_div(r_op) ? w_div_done : (r_cnt == c_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_acc_hi <= '0;
            r_acc_lo <= w_mag_b;
            r_mcand  <= w_mag_a;
            r_cnt    <= '0;
        end else if (r_state == ITER) begin
            {r_acc_hi, r_acc_lo} <= {w_msum, r_acc_lo[WIDTH-1:1]};
            r_cnt                <= r_cnt + 1'b1;
        end
    end
`endif

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_accept & is_div(i_alu_op)),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_div_done),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    always_comb begin
        w_basic_res = '0;
        case (i_alu_op)
            ALU_ADD:  w_basic_res = i_op_a + i_op_b;
            ALU_SUB:  w_basic_res = i_op_a - i_op_b;
            ALU_SLT:  w_basic_res = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            ALU_SLTU: w_basic_res = {{(WIDTH-1){1'b0}}, (i_op_a < i_op_b)};
            ALU_XOR:  w_basic_res = i_op_a ^ i_op_b;
            ALU_OR:   w_basic_res = i_op_a | i_op_b;
            ALU_AND:  w_basic_res = i_op_a & i_op_b;
            ALU_SLL:  w_basic_res = i_op_a << w_shamt;
            ALU_SRL:  w_basic_res = i_op_a >> w_shamt;
            ALU_SRA:  w_basic_res = $signed(i_op_a) >>> w_shamt;
`ifdef ALU_MC_FAST_MUL_EN
            ALU_MUL:                         w_basic_res = w_fprod[WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: w_basic_res = w_fprod[2*WIDTH-1:WIDTH];
`endif
            default:  w_basic_res = '0;
        endcase
    end

    // Divide-by-zero and sign correction are resolved here; MIN/-1 falls out naturally.
    always_comb begin
        w_fix_res = '0;
        case (r_op)
            ALU_DIV, ALU_DIVU: w_fix_res = r_b_zero ? '1 : (r_neg_q ? -w_quot : w_quot);
            ALU_REM, ALU_REMU: w_fix_res = r_b_zero ? r_op_a : (r_neg_r ? -w_rem : w_rem);
`ifndef ALU_MC_FAST_MUL_EN
            ALU_MUL:                         w_fix_res = w_prod[WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
`endif
            default:           w_fix_res = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= '0;
            r_op_a   <= '0;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= i_alu_op;
            r_op_a   <= i_op_a;
            r_b_zero <= (i_op_b == '0);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            if (!w_go_iter) begin
                r_result <= w_basic_res;
            end
        end else if ((r_state == FIX) && !i_kill) begin
            r_result <= w_fix_res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_kill) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_nxt = w_go_iter ? ITER : DONE;
                ITER: if (w_iter_done) w_state_nxt = FIX;
                FIX:  w_state_nxt = DONE;
                DONE: begin
                    if (w_accept)     w_state_nxt = w_go_iter ? ITER : DONE;
                    else if (i_ready) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            IDLE:      o_ready = 1'b1;
            ITER, FIX: o_busy  = 1'b1;
            DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
            end
            default: ;
        endcase
    end

    assign o_alu_data = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Desc     : Scoreboard testbench for alu_mc (latency, handshake, kill, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_MC_FAST_MUL_EN
    localparam int c_MUL_LAT = 1;
`else
    localparam int c_MUL_LAT = W + 2;
`endif
    localparam int c_DIV_LAT = W + 2;

    logic         i_clk   = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_kill  = 1'b0;
    logic         i_ready = 1'b1;
    logic [4:0]   i_alu_op;
    logic [W-1:0] i_op_a;
    logic [W-1:0] i_op_b;
    logic [W-1:0] o_alu_data;
    logic         o_ready;
    logic         o_valid;
    logic         o_busy;

    int           n_chk  = 0;
    int           n_pass = 0;
    logic [W-1:0] sb_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .i_alu_op   (i_alu_op),
        .i_kill     (i_kill),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_alu_data (o_alu_data),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd3:  return (a < b) ? 32'd1 : 32'd0;
            5'd4:  return a ^ b;
            5'd5:  return a | b;
            5'd6:  return a & b;
            5'd7:  return a << b[4:0];
            5'd8:  return a >> b[4:0];
            5'd9:  return 32'(sa >>> b[4:0]);
            5'd10: begin p = 64'(sa * sb); return p[31:0]; end
            5'd11: begin p = 64'(sa * sb); return p[63:32]; end
            5'd12: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'd14: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            5'd15: return (b == 0) ? '1 : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                return 32'(sa % sb);
            end
            5'd17: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op >= 5'd14 && op <= 5'd17) return c_DIV_LAT;
        if (op >= 5'd10 && op <= 5'd13) return c_MUL_LAT;
        return 1;
    endfunction

    // Every consumed result is checked against the scoreboard.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_valid", W'(o_valid), '0);
            else                  check("sb_result", o_alu_data, sb_q.pop_front());
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge where o_valid is seen.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat, input int exp_busy,
                         input string tag);
        int lat;
        int busy;
        i_valid  = 1'b1;
        i_alu_op = op;
        i_op_a   = a;
        i_op_b   = b;
        sb_q.push_back(exp);
        @(negedge i_clk);
        check({tag, "_ready"}, W'(o_ready), W'(1));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!o_valid && lat < 200) begin
            busy += int'(o_busy);
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, W'(busy), W'(exp_busy));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        i_alu_op = '0;
        i_op_a   = '0;
        i_op_b   = '0;
        repeat (2) @(posedge i_clk); #1;
        check("reset_valid", W'(o_valid), '0);
        check("reset_busy",  W'(o_busy),  '0);
        check("reset_ready", W'(o_ready), W'(1));
        check("reset_data",  o_alu_data,  '0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        issue(ALU_ADD,    32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1,         -1,    "add_wrap");
        issue(ALU_SRA,    32'h8000_0000, 32'd33,        32'hC000_0000, 1,         -1,    "sra");
        issue(ALU_DIVU,   32'd100,       32'd7,         32'd14,        c_DIV_LAT, W + 1, "divu");
        issue(ALU_REMU,   32'd100,       32'd7,         32'd2,         c_DIV_LAT, -1,    "remu");
        issue(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, c_DIV_LAT, -1,    "div_ovf");
        issue(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, c_DIV_LAT, -1,    "rem_ovf");
        issue(ALU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, c_DIV_LAT, -1,    "divu_zero");
        issue(ALU_REMU,   32'd5,         32'd0,         32'd5,         c_DIV_LAT, -1,    "remu_zero");
        issue(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, c_DIV_LAT, -1,    "div_neg");
        issue(ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, c_DIV_LAT, -1,    "rem_neg");
        issue(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, c_MUL_LAT, -1,    "mulh_min");
        issue(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_MUL_LAT, -1,    "mulhu_max");
        issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, c_MUL_LAT, -1,    "mulhsu");
        issue(ALU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, c_MUL_LAT, -1,    "mul_neg");
        issue(ALU_SLT,    32'hFFFF_FFFF, 32'd1,         32'd1,         1,         -1,    "slt");
        issue(ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0,         1,         -1,    "sltu");
        issue(5'd25,      32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1,         -1,    "op_undef");

        for (int k = 0; k < 24; k++) begin
            op = 5'($urandom_range(0, 20));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            issue(op, a, b, model(op, a, b), lat_of(op), -1, "rand");
        end

        // Backpressure: result and o_valid hold, o_ready low, then same-cycle reissue.
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        issue(ALU_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F, 1, -1, "bp_xor");
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", W'(o_valid), W'(1));
            check("bp_data",  o_alu_data,  32'h5A5A_0F0F);
            check("bp_ready", W'(o_ready), '0);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        issue(ALU_OR, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1, -1, "bp_next");

        // Kill during DIVU iteration cycle 10.
        @(posedge i_clk); #1;
        i_valid  = 1'b1;
        i_alu_op = ALU_DIVU;
        i_op_a   = 32'd1000;
        i_op_b   = 32'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        check("kill_pre_busy", W'(o_busy), W'(1));
        i_kill = 1'b1;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        check("kill_idle_ready", W'(o_ready), W'(1));
        check("kill_idle_busy",  W'(o_busy),  '0);
        check("kill_idle_valid", W'(o_valid), '0);
        nv = 0;
        repeat (40) begin
            @(posedge i_clk); #1;
            nv += int'(o_valid);
        end
        check("kill_no_result", W'(nv), '0);
        issue(ALU_ADD, 32'd2, 32'd3, 32'd5, 1, -1, "post_kill_add");

        // Kill wins over a same-cycle accept.
        @(posedge i_clk); #1;
        i_valid  = 1'b1;
        i_kill   = 1'b1;
        i_alu_op = ALU_ADD;
        i_op_a   = 32'd1;
        i_op_b   = 32'd1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_kill  = 1'b0;
        check("kill_block_valid", W'(o_valid), '0);
        check("kill_block_ready", W'(o_ready), W'(1));

        // Asynchronous reset in the middle of a DIV.
        i_valid  = 1'b1;
        i_alu_op = ALU_DIV;
        i_op_a   = 32'd100;
        i_op_b   = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        check("rst_pre_busy", W'(o_busy), W'(1));
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", W'(o_valid), '0);
        check("rst_mid_busy",  W'(o_busy),  '0);
        check("rst_mid_ready", W'(o_ready), W'(1));
        check("rst_mid_data",  o_alu_data,  '0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        issue(ALU_SUB, 32'd10, 32'd3, 32'd7, 1, -1, "post_rst_sub");

        repeat (40) @(posedge i_clk);
        #1;
        check("sb_drained", W'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
